// File: rtl/core_pkg.sv
// ============================================================================
// Module : core_pkg
// Desc   : Shared RV32I decode types: micro-op struct, instruction classes,
//          opcode constants.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package core_pkg;

  typedef enum logic [2:0] {
    TYPE_NONE = 3'd0,
    TYPE_U    = 3'd1,
    TYPE_J    = 3'd2,
    TYPE_B    = 3'd3,
    TYPE_I    = 3'd4,
    TYPE_S    = 3'd5,
    TYPE_R    = 3'd6
  } instr_type_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    instr_type_e instr_type;
    logic [2:0]  alu_op;
    logic [31:0] pc;
    logic        lane_valid;
    logic        illegal;
  } uop_t;

endpackage

`default_nettype wire

// File: rtl/decode_lane.sv
// ============================================================================
// Module : decode_lane
// Desc   : Combinational single-instruction RV32I decoder producing a uop_t.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module decode_lane
  import core_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic        i_lane_valid,
  output uop_t        o_uop
);

  always_comb begin
    o_uop = '0;
    if (i_lane_valid) begin
      o_uop.lane_valid = 1'b1;
      o_uop.pc         = i_pc;
      o_uop.op         = i_instr[6:0];
      if (i_instr[1:0] != 2'b11) begin
        o_uop.illegal = 1'b1;
      end else begin
        case (i_instr[6:0])
          OP_LUI, OP_AUIPC: begin
            o_uop.instr_type = TYPE_U;
            o_uop.rd         = i_instr[11:7];
            o_uop.imm        = {i_instr[31:12], 12'h000};
          end
          OP_JAL: begin
            o_uop.instr_type = TYPE_J;
            o_uop.rd         = i_instr[11:7];
            o_uop.imm        = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
          end
          OP_BRANCH: begin
            o_uop.instr_type = TYPE_B;
            o_uop.rs1        = i_instr[19:15];
            o_uop.rs2        = i_instr[24:20];
            o_uop.funct3     = i_instr[14:12];
            o_uop.imm        = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
          end
          OP_JALR, OP_LOAD, OP_IMM, OP_FENCE, OP_SYSTEM: begin
            o_uop.instr_type = TYPE_I;
            o_uop.rd         = i_instr[11:7];
            o_uop.rs1        = i_instr[19:15];
            o_uop.funct3     = i_instr[14:12];
            o_uop.imm        = {{20{i_instr[31]}}, i_instr[31:20]};
            // Shift-immediates carry funct7 and a 5-bit unsigned shamt.
            if (i_instr[6:0] == OP_IMM && i_instr[13:12] == 2'b01) begin
              o_uop.funct7 = i_instr[31:25];
              o_uop.imm    = {27'd0, i_instr[24:20]};
            end
          end
          OP_STORE: begin
            o_uop.instr_type = TYPE_S;
            o_uop.rs1        = i_instr[19:15];
            o_uop.rs2        = i_instr[24:20];
            o_uop.funct3     = i_instr[14:12];
            o_uop.imm        = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
          end
          OP_REG: begin
            o_uop.instr_type = TYPE_R;
            o_uop.rd         = i_instr[11:7];
            o_uop.rs1        = i_instr[19:15];
            o_uop.rs2        = i_instr[24:20];
            o_uop.funct3     = i_instr[14:12];
            o_uop.funct7     = i_instr[31:25];
          end
          default: o_uop.illegal = 1'b1;
        endcase
      end
      o_uop.alu_op = (o_uop.instr_type == TYPE_S) ? 3'd0 : o_uop.funct3;
    end
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// ============================================================================
// Module : decode_stage
// Desc   : Registered LANES-wide decode stage with valid/ready on both sides.
//          Define DECODE_SKID_EN to add a one-group skid buffer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module decode_stage
  import core_pkg::*;
#(
  parameter int LANES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_instr,
  input  logic [LANES*32-1:0]   in_pc,
  input  logic [LANES-1:0]      in_lane_valid,
  output logic                  out_valid,
  input  logic                  out_ready,
  output uop_t [LANES-1:0]      out_uop
);

  uop_t [LANES-1:0] w_uop;
  logic             w_in_fire;
  logic             w_out_free;
  logic             r_out_valid;
  uop_t [LANES-1:0] r_out_uop;

  generate
    for (genvar g = 0; g < LANES; g++) begin : g_lane
      decode_lane u_lane (
        .i_instr      (in_instr[g*32 +: 32]),
        .i_pc         (in_pc[g*32 +: 32]),
        .i_lane_valid (in_lane_valid[g]),
        .o_uop        (w_uop[g])
      );
    end
  endgenerate

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_free = !r_out_valid || out_ready;
  assign out_valid  = r_out_valid;
  assign out_uop    = r_out_uop;

`ifdef DECODE_SKID_EN
  logic             r_skid_full;
  uop_t [LANES-1:0] r_skid_uop;

  // Ready comes straight from a flop, breaking the out_ready -> in_ready path.
  assign in_ready = !r_skid_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_uop   <= '0;
      r_skid_full <= 1'b0;
      r_skid_uop  <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_skid_full <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_full) begin
        r_out_uop   <= r_skid_uop;
        r_out_valid <= 1'b1;
        r_skid_full <= 1'b0;
      end else if (w_in_fire) begin
        r_out_uop   <= w_uop;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid_uop  <= w_uop;
      r_skid_full <= 1'b1;
    end
  end
`else
  assign in_ready = w_out_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_uop   <= '0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_in_fire) begin
      r_out_uop   <= w_uop;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_decode_stage.sv
// ============================================================================
// Module : tb_decode_stage
// Desc   : Scoreboard bench for decode_stage (LANES=2); honours DECODE_SKID_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_decode_stage;
  import core_pkg::*;

  localparam int LANES = 2;

  logic                clk = 1'b0;
  logic                rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [LANES*32-1:0] in_instr, in_pc;
  logic [LANES-1:0]    in_lane_valid;
  uop_t [LANES-1:0]    out_uop;

  int   n_checks = 0;
  int   n_fail   = 0;
  uop_t q0[$];
  uop_t q1[$];
  logic exp_lat  = 1'b0;
  logic skid_ld  = 1'b0;

  always #5 clk = ~clk;

  decode_stage #(.LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .in_lane_valid(in_lane_valid),
    .out_valid(out_valid), .out_ready(out_ready), .out_uop(out_uop)
  );

  function automatic uop_t mk(input logic [6:0] op, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input instr_type_e t,
                              input logic [2:0] alu, input logic [31:0] pc,
                              input logic ill);
    uop_t u;
    u = '0;
    u.op = op; u.rd = rd; u.rs1 = rs1; u.rs2 = rs2; u.funct3 = f3;
    u.funct7 = f7; u.imm = imm; u.instr_type = t; u.alu_op = alu;
    u.pc = pc; u.lane_valid = 1'b1; u.illegal = ill;
    return u;
  endfunction

  task automatic chk1(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the group is accepted.
  task automatic send(input logic [31:0] i0, input logic [31:0] p0,
                      input logic [31:0] i1, input logic [31:0] p1,
                      input logic [1:0] lv, input uop_t e0, input uop_t e1);
    logic rdy, fl;
    rdy = 1'b0;
    fl  = 1'b0;
    in_instr = {i1, i0};
    in_pc = {p1, p0};
    in_lane_valid = lv;
    in_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      rdy = in_ready;
      fl  = flush;
      @(posedge clk);
      if (rdy) break;
    end
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for 50 cycles, required 1");
    end else if (!fl) begin
      q0.push_back(e0);
      q1.push_back(e1);
    end
    #1 in_valid = 1'b0;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_lat = 1'b0;
      skid_ld = 1'b0;
    end else begin
      if (exp_lat) chk1("latency_out_valid", 128'(out_valid), 128'(1'b1));
`ifdef DECODE_SKID_EN
      if (skid_ld) chk1("skid_in_ready_fall", 128'(in_ready), 128'(1'b0));
`endif
      if (out_valid && out_ready && !flush) begin
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_group: got lane0 %h, required no output", out_uop[0]);
        end else begin
          chk1("uop_lane0", 128'(out_uop[0]), 128'(q0.pop_front()));
          chk1("uop_lane1", 128'(out_uop[1]), 128'(q1.pop_front()));
        end
      end
      exp_lat = in_valid && in_ready && (!out_valid || out_ready) && !flush;
      skid_ld = in_valid && in_ready && out_valid && !out_ready && !flush;
    end
  end

  localparam logic [31:0] ADD_X3 = 32'h002081B3;

  initial begin
    uop_t z;
    z = '0;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0; in_lane_valid = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("reset_out_valid", 128'(out_valid), 128'(1'b0));
    chk1("reset_in_ready", 128'(in_ready), 128'(1'b1));
    chk1("reset_out_uop", 128'(out_uop), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    // Directed single-lane vectors; lane 1 carries an instruction but is invalid.
    send(32'h123452B7, 32'h100, ADD_X3, 32'h104, 2'b01,
         mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, TYPE_U, 3'd0, 32'h100, 1'b0), z);
    send(32'hFFF00093, 32'h104, ADD_X3, 32'h108, 2'b01,
         mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, TYPE_I, 3'd0, 32'h104, 1'b0), z);
    send(32'h0020A423, 32'h108, ADD_X3, 32'h10C, 2'b01,
         mk(7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'h8, TYPE_S, 3'd0, 32'h108, 1'b0), z);
    send(32'hFE000EE3, 32'h10C, ADD_X3, 32'h110, 2'b01,
         mk(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, TYPE_B, 3'd0, 32'h10C, 1'b0), z);
    send(32'h00000000, 32'h110, ADD_X3, 32'h114, 2'b01,
         mk(7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, TYPE_NONE, 3'd0, 32'h110, 1'b1), z);
    send(32'h0000007F, 32'h114, ADD_X3, 32'h118, 2'b01,
         mk(7'h7F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0, TYPE_NONE, 3'd0, 32'h114, 1'b1), z);
    send(32'h40535293, 32'h118, ADD_X3, 32'h11C, 2'b01,
         mk(7'h13, 5'd5, 5'd6, 5'd0, 3'd5, 7'h20, 32'h5, TYPE_I, 3'd5, 32'h118, 1'b0), z);
    send(32'h0080006F, 32'h11C, ADD_X3, 32'h120, 2'b01,
         mk(7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h8, TYPE_J, 3'd0, 32'h11C, 1'b0), z);
    send(ADD_X3, 32'h120, 32'h123452B7, 32'h124, 2'b11,
         mk(7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, TYPE_R, 3'd0, 32'h120, 1'b0),
         mk(7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, TYPE_U, 3'd0, 32'h124, 1'b0));
    repeat (2) @(posedge clk); #1;

    // Six-group stream with consumer stall in cycles 2-4.
    fork
      begin
        for (int k = 1; k <= 6; k++) begin
          send((32'(k) << 12) | (32'(k) << 7) | 32'h37, 32'h200 + 32'(4*k), ADD_X3, 32'h0, 2'b01,
               mk(7'h37, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k) << 12, TYPE_U, 3'd0,
                  32'h200 + 32'(4*k), 1'b0), z);
        end
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (6) @(posedge clk); #1;

    // Flush while stalled with held groups and a group offered on the same edge.
    out_ready = 1'b0;
    send(32'h00100093, 32'h300, ADD_X3, 32'h0, 2'b01, z, z);
`ifdef DECODE_SKID_EN
    send(32'h00200113, 32'h304, ADD_X3, 32'h0, 2'b01, z, z);
`endif
    q0.delete();
    q1.delete();
    in_instr = {ADD_X3, 32'h00300193};
    in_pc = {32'h0, 32'h308};
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk1("flush_out_valid", 128'(out_valid), 128'(1'b0));
    chk1("flush_in_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1 out_ready = 1'b1;
    send(32'h00400213, 32'h30C, ADD_X3, 32'h0, 2'b01,
         mk(7'h13, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'h4, TYPE_I, 3'd0, 32'h30C, 1'b0), z);
    repeat (3) @(posedge clk); #1;

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    send(32'h123452B7, 32'h400, ADD_X3, 32'h0, 2'b01, z, z);
    #2 rst_n = 1'b0;
    #1;
    chk1("async_rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk1("async_rst_in_ready", 128'(in_ready), 128'(1'b1));
    chk1("async_rst_out_uop", 128'(out_uop), 128'(0));
    q0.delete();
    q1.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'hFFF00093, 32'h500, ADD_X3, 32'h0, 2'b01,
         mk(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, TYPE_I, 3'd0, 32'h500, 1'b0), z);
    repeat (4) @(posedge clk); #1;

    chk1("scoreboard_drained", 128'(q0.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
